ysyx_24100012_wbu: RTL and testbench
====================================

YSYX_24100012_WBU -- requirements
Module: ysyx_24100012_wbu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of result data and register write data.
REQ-002 SHALL have parameter INDEX_LEN, default 5, width of register index.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream result valid.
REQ-006 SHALL have port in_ready  output  1  WBU can accept a result this cycle.
REQ-007 SHALL have ports in_rd (input, INDEX_LEN), in_wen (input, 1), in_is_load (input, 1), in_funct3 (input, 3), in_addr_lo (input, 2), in_alu_res (input, DATA_WIDTH); these carry the destination, write enable, load flag, load width code, byte offset and ALU result.
REQ-008 SHALL have ports mem_rvalid (input, 1) and mem_rdata (input, DATA_WIDTH), the load response word.
REQ-009 SHALL have ports RegWEn (output, 1), RegWriteIndex (output, INDEX_LEN) and RegWriteData (output, DATA_WIDTH), which drive the register file write port directly.
REQ-010 SHALL have port commit  output  1  one-cycle pulse per retired instruction.
REQ-011 SHALL have ports busy (output, 1) and busy_rd (output, INDEX_LEN), the pending-write hazard information for upstream.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_MEM and COMMIT.
REQ-013 SHALL drive in_ready=1 in IDLE and COMMIT, and in_ready=0 in WAIT_MEM.
REQ-014 SHALL, on in_valid&in_ready, latch rd/wen/is_load/funct3/addr_lo/alu_res, then go to WAIT_MEM if is_load, else to COMMIT.
REQ-015 SHALL, in COMMIT with no accept, go to IDLE; with an accept, apply REQ-014 so that back-to-back non-loads retire one per cycle.
REQ-016 SHALL, in WAIT_MEM, on mem_rvalid, latch the extracted load value and go to COMMIT; WAIT_MEM SHALL hold indefinitely until mem_rvalid.
REQ-017 SHALL ignore mem_rvalid outside WAIT_MEM.
REQ-018 SHALL extract load data as follows: funct3 000 sign-extends byte mem_rdata[8*addr_lo+:8]; 100 zero-extends that byte; 001 sign-extends halfword mem_rdata[16*addr_lo[1]+:16]; 101 zero-extends that halfword; 010 and all other codes pass the full word.
REQ-019 SHALL register RegWEn, RegWriteIndex, RegWriteData and commit, asserting them only in COMMIT.
REQ-020 SHALL set RegWEn = latched wen AND latched rd != 0; commit=1 in COMMIT regardless of wen.
REQ-021 SHALL have latency as follows: a non-load accepted at edge N drives RegWEn in cycle N+1; for a load, mem_rvalid sampled at edge M drives RegWEn in cycle M+1.
REQ-022 SHALL drive busy=1 whenever state != IDLE and the latched wen=1 and latched rd != 0; busy_rd SHALL equal the latched rd.
REQ-023 SHALL hold RegWriteIndex/RegWriteData stable outside COMMIT, and they SHALL NOT be used outside COMMIT.

Reset
REQ-024 SHALL, on rst low, asynchronously enter IDLE; RegWEn=0, commit=0, RegWriteIndex=0, RegWriteData=0, busy=0, busy_rd=0; in_ready SHALL be 1 once the state is IDLE.
REQ-025 SHALL, on rst asserted in WAIT_MEM or COMMIT, discard the pending result with no register write; a later mem_rvalid SHALL be ignored.

Configuration
REQ-026 SHALL, with YSYX_24100012_WBU_INSTCNT_EN defined, add output inst_cnt (64 bits), reset to 0, incremented by 1 at each commit pulse and wrapping at 2^64.
REQ-027 SHALL, without YSYX_24100012_WBU_INSTCNT_EN, omit the inst_cnt port and counter; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: non-load rd=5, alu_res=0x12345678 accepted -> next cycle RegWEn=1, RegWriteIndex=5, RegWriteData=0x12345678, commit=1.
REQ-029 SHALL cover: lb at addr_lo=3, mem_rdata=0x80FF_0000 after 4 wait cycles -> in_ready=0 while waiting; then RegWriteData=0xFFFFFF80, one commit.
REQ-030 SHALL cover: lhu at addr_lo=2, mem_rdata=0xBEEF_1234 -> RegWriteData=0x0000BEEF; lh gives 0xFFFFBEEF.
REQ-031 SHALL cover: three back-to-back non-loads to rd=1,2,0 -> commits on 3 consecutive cycles; RegWEn is 1,1,0.
REQ-032 SHALL cover: rst low during WAIT_MEM, then mem_rvalid -> no RegWEn and no commit; state is IDLE.
REQ-033 SHALL cover: with YSYX_24100012_WBU_INSTCNT_EN defined, 10 retirements -> inst_cnt=10; after reset inst_cnt=0.

Source files
------------

// File: rtl/ysyx_24100012_wbu.sv
// rtl/ysyx_24100012_wbu.sv - write-back unit: load extraction, register write and commit pulse
//
// Purpose: accepts one execute result at a time. Non-loads retire in the cycle
// after acceptance. Loads wait for the memory response, then retire in the cycle
// after mem_rvalid. The register-file write port is driven from registers.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   in_valid/in_ready          upstream result handshake
//   in_rd, in_wen, in_is_load  destination, write enable, load flag
//   in_funct3, in_addr_lo      load width code, byte offset within the word
//   in_alu_res                 ALU result for non-loads
//   mem_rvalid, mem_rdata      load response word
//   RegWEn, RegWriteIndex,
//   RegWriteData               register-file write port
//   commit                     one-cycle pulse per retired instruction
//   busy, busy_rd              pending-write hazard information for upstream
//   inst_cnt                   64-bit retired instruction count, present only
//                              with YSYX_24100012_WBU_INSTCNT_EN defined
module ysyx_24100012_wbu #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_LEN  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INDEX_LEN-1:0]  in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  RegWEn,
  output logic [INDEX_LEN-1:0]  RegWriteIndex,
  output logic [DATA_WIDTH-1:0] RegWriteData,
  output logic                  commit,
  output logic                  busy,
  output logic [INDEX_LEN-1:0]  busy_rd
`ifdef YSYX_24100012_WBU_INSTCNT_EN
  ,
  output logic [63:0]           inst_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched instruction fields. The load flag is carried by the state itself
  // (WAIT_MEM), and the ALU result goes straight into RegWriteData on accept,
  // so neither needs its own register.
  logic [INDEX_LEN-1:0] l_rd;
  logic                 l_wen;
  logic [2:0]           l_funct3;
  logic [1:0]           l_addr_lo;

  logic                  accept;
  logic                  mem_done;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_val;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;
  assign mem_done = (state == WAIT_MEM) && mem_rvalid;

  assign busy    = (state != IDLE) && l_wen && (l_rd != '0);
  assign busy_rd = l_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COMMIT: begin
        if (accept) begin
          state_next = in_is_load ? WAIT_MEM : COMMIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_next = COMMIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Load data extraction from the latched width code and byte offset.
  always_comb begin
    ld_byte  = mem_rdata[7:0];
    ld_half  = mem_rdata[15:0];
    load_val = mem_rdata;
    case (l_addr_lo)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = l_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (l_funct3)
      3'b000:  load_val = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  load_val = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Write-port registers are loaded on the same edge the FSM enters COMMIT,
  // so they are valid exactly during COMMIT. Index/data hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_rd          <= '0;
      l_wen         <= 1'b0;
      l_funct3      <= 3'b000;
      l_addr_lo     <= 2'b00;
      RegWEn        <= 1'b0;
      RegWriteIndex <= '0;
      RegWriteData  <= '0;
      commit        <= 1'b0;
    end else begin
      RegWEn <= 1'b0;
      commit <= 1'b0;
      if (accept) begin
        l_rd      <= in_rd;
        l_wen     <= in_wen;
        l_funct3  <= in_funct3;
        l_addr_lo <= in_addr_lo;
        if (!in_is_load) begin
          RegWEn        <= in_wen && (in_rd != '0);
          RegWriteIndex <= in_rd;
          RegWriteData  <= in_alu_res;
          commit        <= 1'b1;
        end
      end else if (mem_done) begin
        RegWEn        <= l_wen && (l_rd != '0);
        RegWriteIndex <= l_rd;
        RegWriteData  <= load_val;
        commit        <= 1'b1;
      end
    end
  end

`ifdef YSYX_24100012_WBU_INSTCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_cnt <= 64'd0;
    end else if (commit) begin
      inst_cnt <= inst_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100012_wbu.sv
// tb/tb_ysyx_24100012_wbu.sv - self-checking bench for ysyx_24100012_wbu
module tb_ysyx_24100012_wbu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWEn;
  logic [4:0]  RegWriteIndex;
  logic [31:0] RegWriteData;
  logic        commit;
  logic        busy;
  logic [4:0]  busy_rd;
`ifdef YSYX_24100012_WBU_INSTCNT_EN
  logic [63:0] inst_cnt;
`endif

  ysyx_24100012_wbu #(.DATA_WIDTH(32), .INDEX_LEN(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_res(in_alu_res),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWEn(RegWEn), .RegWriteIndex(RegWriteIndex), .RegWriteData(RegWriteData),
    .commit(commit), .busy(busy), .busy_rd(busy_rd)
`ifdef YSYX_24100012_WBU_INSTCNT_EN
    , .inst_cnt(inst_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: result of an instruction from the ISA load rules, in plain arithmetic.
  function automatic logic [31:0] ref_result(input logic is_load, input logic [2:0] f3,
                                             input logic [1:0] al, input logic [31:0] alu,
                                             input logic [31:0] rdata);
    int unsigned w, b, h;
    if (!is_load) return alu;
    w = rdata;
    b = (w >> (8 * al)) % 256;
    h = (w >> (16 * (al / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Every commit pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (commit) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", commit, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("commit_wen", RegWEn, e.wen);
          check("commit_idx", RegWriteIndex, e.idx);
          check("commit_data", RegWriteData, e.data);
        end
      end else begin
        check("wen_outside_commit", RegWEn, 1'b0);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1'b1);
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic is_load,
                       input logic [2:0] f3, input logic [1:0] al, input logic [31:0] alu,
                       input logic [31:0] rdata, input int waits,
                       input logic [31:0] exp_data, input logic exp_wen);
    exp_q.push_back({exp_wen, rd, exp_data});
    in_valid   = 1'b1;
    in_rd      = rd;
    in_wen     = wen;
    in_is_load = is_load;
    in_funct3  = f3;
    in_addr_lo = al;
    in_alu_res = alu;
    mem_rvalid = 1'($urandom_range(0, 1));  // must be ignored outside WAIT_MEM
    mem_rdata  = $urandom;
    wait_ready();
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    in_rd      = 5'($urandom);
    in_alu_res = $urandom;
    if (!is_load) begin
      @(negedge clk);
      check("nonload_latency", commit, 1'b1);
    end else begin
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        check("ready_low_in_wait", in_ready, 1'b0);
        check("busy_in_wait", busy, wen && (rd != 0));
        check("busy_rd_in_wait", busy_rd, rd);
        check("no_commit_in_wait", commit, 1'b0);
        @(posedge clk);
        #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      @(negedge clk);
      check("load_latency", commit, 1'b1);
      @(negedge clk);
      check("single_commit", commit, 1'b0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", in_ready, 1'b1);
    check("rst_wen", RegWEn, 1'b0);
    check("rst_commit", commit, 1'b0);
    check("rst_idx", RegWriteIndex, 5'd0);
    check("rst_data", RegWriteData, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_busy_rd", busy_rd, 5'd0);
  endtask

  initial begin
    tbl[0]  = '{5'd5,  1'b1, 1'b0, 3'b000, 2'd0, 32'h12345678, 32'h0,         0, 32'h12345678, 1'b1};
    tbl[1]  = '{5'd7,  1'b1, 1'b1, 3'b000, 2'd3, 32'h0,        32'h80FF_0000, 4, 32'hFFFFFF80, 1'b1};
    tbl[2]  = '{5'd8,  1'b1, 1'b1, 3'b101, 2'd2, 32'h0,        32'hBEEF_1234, 1, 32'h0000BEEF, 1'b1};
    tbl[3]  = '{5'd9,  1'b1, 1'b1, 3'b001, 2'd2, 32'h0,        32'hBEEF_1234, 2, 32'hFFFFBEEF, 1'b1};
    tbl[4]  = '{5'd10, 1'b1, 1'b1, 3'b100, 2'd1, 32'h0,        32'h0000_9A00, 1, 32'h0000009A, 1'b1};
    tbl[5]  = '{5'd11, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0,        32'hDEADBEEF,  3, 32'hDEADBEEF, 1'b1};
    tbl[6]  = '{5'd12, 1'b1, 1'b1, 3'b011, 2'd1, 32'h0,        32'h11223344,  1, 32'h11223344, 1'b1};
    tbl[7]  = '{5'd0,  1'b1, 1'b1, 3'b010, 2'd0, 32'h0,        32'hCAFEF00D,  1, 32'hCAFEF00D, 1'b0};
    tbl[8]  = '{5'd3,  1'b0, 1'b0, 3'b000, 2'd0, 32'h55AA55AA, 32'h0,         0, 32'h55AA55AA, 1'b0};
    tbl[9]  = '{5'd13, 1'b1, 1'b1, 3'b001, 2'd0, 32'h0,        32'h0000_8001, 0, 32'hFFFF8001, 1'b1};
    tbl[10] = '{5'd14, 1'b1, 1'b1, 3'b000, 2'd0, 32'h0,        32'h0000_007F, 0, 32'h0000007F, 1'b1};
    tbl[11] = '{5'd31, 1'b1, 1'b0, 3'b010, 2'd3, 32'hFFFFFFFF, 32'h0,         0, 32'hFFFFFFFF, 1'b1};

    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; in_alu_res = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
`ifdef YSYX_24100012_WBU_INSTCNT_EN
    check("rst_inst_cnt", inst_cnt, 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].rd, tbl[i].wen, tbl[i].is_load, tbl[i].f3, tbl[i].addr_lo,
            tbl[i].alu, tbl[i].rdata, tbl[i].waits, tbl[i].exp_data, tbl[i].exp_wen);
    end

    // Back-to-back non-loads retire on consecutive cycles.
    wait_ready();
    exp_q.push_back({1'b1, 5'd1, 32'hA1});
    exp_q.push_back({1'b1, 5'd2, 32'hB2});
    exp_q.push_back({1'b0, 5'd0, 32'hC3});
    in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1; in_rd = 5'd1; in_alu_res = 32'hA1;
    @(posedge clk); #1;
    in_rd = 5'd2; in_alu_res = 32'hB2;
    @(negedge clk);
    check("b2b_commit0", commit, 1'b1);
    check("b2b_wen0", RegWEn, 1'b1);
    @(posedge clk); #1;
    in_rd = 5'd0; in_alu_res = 32'hC3;
    @(negedge clk);
    check("b2b_commit1", commit, 1'b1);
    check("b2b_wen1", RegWEn, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_commit2", commit, 1'b1);
    check("b2b_wen2", RegWEn, 1'b0);
    @(negedge clk);
    check("b2b_done", commit, 1'b0);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  rd;
      logic        wen, ld;
      logic [2:0]  f3;
      logic [1:0]  al;
      logic [31:0] alu, rdata;
      rd = 5'($urandom); wen = 1'($urandom); ld = 1'($urandom);
      f3 = 3'($urandom); al = 2'($urandom); alu = $urandom; rdata = $urandom;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      issue(rd, wen, ld, f3, al, alu, rdata, $urandom_range(0, 3),
            ref_result(ld, f3, al, alu, rdata), wen && (rd != 0));
    end

    // Reset during WAIT_MEM discards the load; a late response is ignored.
    wait_ready();
    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1; in_rd = 5'd9; in_funct3 = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", busy, 1'b1);
    check("wait_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("post_rst_commit", commit, 1'b0);
    check("post_rst_wen", RegWEn, 1'b0);
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

`ifdef YSYX_24100012_WBU_INSTCNT_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(5'(i + 1), 1'b1, 1'b0, 3'b000, 2'd0, 32'(i), 32'h0, 0, 32'(i), 1'b1);
    end
    repeat (2) @(negedge clk);
    check("inst_cnt_10", inst_cnt, 64'd10);
    rst = 1'b0;
    #1;
    check("inst_cnt_rst", inst_cnt, 64'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("pending_commits", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
